// File: rtl/dm_responder.sv
// dm_responder: data-memory port responder with RAM below IO_BASE and cycle/LED/timer registers above. Ports: clk, rst, ena/wea/addra/dina access, registered douta, led[7:0], timer_irq.
module dm_responder #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int IO_BASE = 124
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  output logic [7:0]        led,
  output logic              timer_irq
);
  localparam int A_CYC  = IO_BASE;
  localparam int A_LED  = IO_BASE + 1;
  localparam int A_TCMP = IO_BASE + 2;
  localparam int A_TST  = IO_BASE + 3;
  logic [DATA_W-1:0] mem [IO_BASE];
  logic [DATA_W-1:0] cycle, tcnt, tcmp, rdata;
  logic [31:0] a;
  logic flag, io, wr, wr_tcmp, match;
  assign a         = 32'(addra);
  assign io        = a >= IO_BASE;
  assign wr        = ena && wea && !rst;
  assign wr_tcmp   = wr && a == A_TCMP;
  assign match     = tcmp != '0 && tcnt == tcmp - DATA_W'(1);
  assign timer_irq = flag;
  always_comb
    rdata = !io          ? mem[addra] :
            a == A_CYC   ? cycle :
            a == A_LED   ? DATA_W'(led) :
            a == A_TCMP  ? tcmp :
            a == A_TST   ? DATA_W'(flag) : '0;
  always_ff @(posedge clk)
    if (wr && !io) mem[addra] <= dina;
  always_ff @(posedge clk) begin
    if (rst) begin
      douta <= '0;
      led   <= '0;
      cycle <= '0;
      tcnt  <= '0;
      tcmp  <= '0;
      flag  <= 1'b0;
    end else begin
      cycle <= cycle + DATA_W'(1);
      if (ena) douta <= rdata;
      if (wr && a == A_LED) led <= dina[7:0];
      if (wr_tcmp) begin
        tcmp <= dina;
        tcnt <= '0;
      end else if (match) tcnt <= '0;
      else if (tcmp != '0) tcnt <= tcnt + DATA_W'(1);
      // a match always sets the flag unless a TCMP write pre-empts it; W1C only clears when no set
      flag <= (match && !wr_tcmp) || (flag && !(wr && a == A_TST && dina[0]));
    end
  end
endmodule
